// File: rtl/avl_stream_pkg.sv
// Shared beat format, FSM state encodings and saturating counter helper for the packet FIFO.
// Latency: none (types and functions only).
// Backpressure: none (types and functions only).
package avl_stream_pkg;

   localparam int AVL_WIDTH   = 512;
   localparam int AVL_NUM     = 2;
   localparam int AVL_EMPTY_W = $clog2(AVL_WIDTH / 8);

   // One stored beat; kept exactly as received on the rx port.
   typedef struct packed {
      logic [AVL_WIDTH-1:0]   data;
      logic                   sop;
      logic                   eop;
      logic [AVL_EMPTY_W-1:0] empty;
      logic [AVL_NUM-1:0]     channel;
   } t_avl_beat;

   typedef enum logic {
      RX_IDLE   = 1'b0,
      RX_IN_PKT = 1'b1
   } t_rx_state;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_CUT  = 2'd2
   } t_tx_state;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/avl_stream_if.sv
// Avalon-ST style beat stream bundle with ready latency 0.
// Latency: none (wiring only).
// Backpressure: ready from the sink; almost_full is an early warning from the sink.
interface avl_stream_if #(
   parameter int WIDTH = 512,
   parameter int NUM   = 2
);
   localparam int EW = $clog2(WIDTH / 8);

   logic             valid;
   logic             ready;
   logic             almost_full;
   logic [WIDTH-1:0] data;
   logic             sop;
   logic             eop;
   logic [EW-1:0]    empty;
   logic [NUM-1:0]   channel;

   modport rx (input valid, data, sop, eop, empty, channel, output ready, almost_full);
   modport tx (output valid, data, sop, eop, empty, channel, input ready);

endinterface

// File: rtl/avl_pkt_fifo_ram.sv
// Simple dual-port beat storage, one write port and one read port.
// Latency: read data appears the cycle after re_i; the read register holds until the next read.
// Backpressure: none; the caller guarantees it never writes a full RAM or reads an empty one.
module avl_pkt_fifo_ram
   import avl_stream_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  t_avl_beat     wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output t_avl_beat     rdata_o
);

   t_avl_beat mem_q [DEPTH];
   t_avl_beat rdata_q;

   // Storage array write; no reset so it maps onto RAM macros.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port; cleared on reset so the tx data bus reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/avl_stream_pkt_fifo.sv
// Store-and-forward packet FIFO; orphan beats dropped, oversized packets released cut-through.
// Latency: eop stored in cycle N -> head sop valid on out_if in N+2; then 1 beat/cycle.
// Backpressure: in_if.ready registered (occupancy < DEPTH); out_if beat held until out_if.ready.
module avl_stream_pkt_fifo
   import avl_stream_pkg::*;
#(
   parameter int WIDTH     = AVL_WIDTH,
   parameter int NUM       = AVL_NUM,
   parameter int DEPTH     = 64,
   parameter int AF_THRESH = DEPTH - 8,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   avl_stream_if.rx      in_if,
   avl_stream_if.tx      out_if,
   output logic [CW-1:0] occupancy,
   output logic [CW-1:0] pkt_cnt,
   output logic [31:0]   drop_cnt,
   output logic [31:0]   err_cnt
);

   t_rx_state     rx_state_q, rx_state_d;
   t_tx_state     tx_state_q, tx_state_d;
   logic [CW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] occ_q, occ_d;
   logic [CW-1:0] pkt_q, pkt_d;
   logic          rdy_q, af_q;
   logic [31:0]   drop_q, err_q;

   // Show-ahead stage: ob_q[0] is the oldest beat; rv_q marks a beat sitting in the RAM read register.
   t_avl_beat     ob_q [2];
   t_avl_beat     ob_d [2];
   logic [1:0]    ob_cnt_q, ob_cnt_d;
   logic          rv_q;

   t_avl_beat     wbeat, ram_rdata, head;
   logic          in_acc, store, drop, err;
   logic          ram_empty, head_vld, tx_vld, pop, rd_en, stage_push;
   logic [2:0]    stage_after;

   assign ram_empty = (wr_ptr_q == rd_ptr_q);
   assign in_acc    = in_if.valid && rdy_q;

   // Pack the incoming beat unmodified into the storage format.
   always_comb begin
      wbeat         = '0;
      wbeat.data    = in_if.data[WIDTH-1:0];
      wbeat.sop     = in_if.sop;
      wbeat.eop     = in_if.eop;
      wbeat.empty   = in_if.empty;
      wbeat.channel = in_if.channel[NUM-1:0];
   end

   // Rx FSM next state: store beats that belong to a packet, drop orphans, flag sop inside a packet.
   always_comb begin
      rx_state_d = rx_state_q;
      store      = in_acc && (in_if.sop || (rx_state_q == RX_IN_PKT));
      drop       = in_acc && !in_if.sop && (rx_state_q == RX_IDLE);
      err        = in_acc && in_if.sop && (rx_state_q == RX_IN_PKT);
      if (store) begin
         rx_state_d = in_if.eop ? RX_IDLE : RX_IN_PKT;
      end
   end

   // Output path: present the stage head (or the read register directly when the stage is empty)
   // and prefetch from RAM while at most two beats will sit between RAM and the port.
   always_comb begin
      head        = (ob_cnt_q != 2'd0) ? ob_q[0] : ram_rdata;
      head_vld    = (ob_cnt_q != 2'd0) || rv_q;
      tx_vld      = head_vld && (tx_state_q != TX_IDLE);
      pop         = tx_vld && out_if.ready;
      stage_after = {1'b0, ob_cnt_q} + {2'b00, rv_q} - {2'b00, pop};
      rd_en       = !ram_empty && (stage_after < 3'd2);
      // A read-register beat consumed straight from the port never enters the stage.
      stage_push  = rv_q && !(pop && (ob_cnt_q == 2'd0));
   end

   // Show-ahead stage next state: shift out on pop, append the arriving read data.
   always_comb begin
      ob_d     = ob_q;
      ob_cnt_d = ob_cnt_q;
      if (pop && (ob_cnt_q != 2'd0)) begin
         ob_d[0]  = ob_q[1];
         ob_cnt_d = ob_cnt_q - 2'd1;
      end
      if (stage_push) begin
         ob_d[ob_cnt_d[0]] = ram_rdata;
         ob_cnt_d          = ob_cnt_d + 2'd1;
      end
   end

   // Beat and packet bookkeeping; occupancy spans RAM, read register and stage.
   always_comb begin
      occ_d = occ_q + CW'(store) - CW'(pop);
      pkt_d = pkt_q + CW'(store && in_if.eop) - CW'(pop && head.eop);
   end

   // Tx FSM next state: whole packets via SEND, a full FIFO with no complete packet via CUT.
   always_comb begin
      tx_state_d = tx_state_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (pkt_q != '0) begin
               tx_state_d = TX_SEND;
            end else if (occ_q == CW'(DEPTH)) begin
               tx_state_d = TX_CUT;
            end
         end
         TX_SEND: begin
            if (pop && head.eop) begin
               tx_state_d = (pkt_d != '0) ? TX_SEND : TX_IDLE;
            end
         end
         TX_CUT: begin
            if (pop && head.eop) begin
               tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Control state, pointers, counters and registered upstream flow control.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= RX_IDLE;
         tx_state_q <= TX_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         pkt_q      <= '0;
         rdy_q      <= 1'b0;
         af_q       <= 1'b0;
         drop_q     <= '0;
         err_q      <= '0;
         ob_cnt_q   <= '0;
         rv_q       <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         tx_state_q <= tx_state_d;
         if (store) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         occ_q    <= occ_d;
         pkt_q    <= pkt_d;
         rdy_q    <= (occ_d < CW'(DEPTH));
         af_q     <= (occ_d >= CW'(AF_THRESH));
         ob_cnt_q <= ob_cnt_d;
         rv_q     <= rd_en;
         if (drop) begin
            drop_q <= sat_inc32(drop_q);
         end
         if (err) begin
            err_q <= sat_inc32(err_q);
         end
      end
   end

   // Stage data registers; cleared so the tx bus reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ob_q <= '{default: '0};
      end else begin
         ob_q <= ob_d;
      end
   end

   avl_pkt_fifo_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (store),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wbeat),
      .re_i    (rd_en),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   assign in_if.ready       = rdy_q;
   assign in_if.almost_full = af_q;

   assign out_if.valid   = tx_vld;
   assign out_if.data    = head.data[WIDTH-1:0];
   assign out_if.sop     = head.sop;
   assign out_if.eop     = head.eop;
   assign out_if.empty   = head.empty;
   assign out_if.channel = head.channel[NUM-1:0];

   assign occupancy = occ_q;
   assign pkt_cnt   = pkt_q;
   assign drop_cnt  = drop_q;
   assign err_cnt   = err_q;

endmodule
